// File: rtl/pass_pkg.sv
// Shared definitions for the entry keypad and the gate controller:
// entry FSM states and digit width.
package pass_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SEND    = 2'd3
  } pass_state_t;

  function automatic logic is_collecting(input pass_state_t s);
    return (s == ST_WAIT_D1) || (s == ST_WAIT_D2);
  endfunction

endpackage

// File: rtl/pass_entry_timer.sv
// Inactivity timer for digit entry: counts enabled cycles, saturates at
// TIMEOUT_CYCLES-1 and flags that terminal count.
module pass_entry_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TERM_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == TERM_CNT);

endmodule

// File: rtl/pass_entry.sv
// Two-digit pass entry at the car-park entrance: collects digits while a car
// is present and presents them, registered, to the gate controller.
module pass_entry
  import pass_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sensor_entrance,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_clear,
  output logic [DIGIT_W-1:0] password_1,
  output logic [DIGIT_W-1:0] password_2,
  output logic               pass_valid,
  output logic               entry_active,
  output logic               timeout_err
);

  pass_state_t        state, state_next;
  logic [DIGIT_W-1:0] pw1_next, pw2_next;
  logic               timeout_next;
  logic               timer_clear, timer_en, timer_term;

  pass_entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (timer_term)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    pw1_next     = password_1;
    pw2_next     = password_2;
    timeout_next = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (sensor_entrance) state_next = ST_WAIT_D1;
      end
      ST_WAIT_D1, ST_WAIT_D2: begin
        // Car leaving beats a clear, which beats a digit, which beats timeout.
        if (!sensor_entrance) begin
          state_next = ST_IDLE;
          pw1_next   = '0;
          pw2_next   = '0;
        end else if (key_clear) begin
          state_next = ST_WAIT_D1;
          pw1_next   = '0;
          pw2_next   = '0;
        end else if (key_valid) begin
          if (state == ST_WAIT_D1) begin
            pw1_next   = key_code;
            state_next = ST_WAIT_D2;
          end else begin
            pw2_next   = key_code;
            state_next = ST_SEND;
          end
        end else if (timer_term) begin
          state_next   = ST_IDLE;
          pw1_next     = '0;
          pw2_next     = '0;
          timeout_next = 1'b1;
        end
      end
      ST_SEND: begin
        if (!sensor_entrance) begin
          state_next = ST_IDLE;
          pw1_next   = '0;
          pw2_next   = '0;
        end else if (key_clear) begin
          state_next = ST_WAIT_D1;
          pw1_next   = '0;
          pw2_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        pw1_next   = '0;
        pw2_next   = '0;
      end
    endcase
  end

  // The timer only runs while waiting for a digit and restarts on any
  // state change or clear, so each new digit gets the full window.
  assign timer_en    = is_collecting(state);
  assign timer_clear = !is_collecting(state) || (state_next != state) || key_clear;

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      password_1   <= '0;
      password_2   <= '0;
      pass_valid   <= 1'b0;
      entry_active <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_next;
      password_1   <= pw1_next;
      password_2   <= pw2_next;
      pass_valid   <= (state_next == ST_SEND);
      entry_active <= is_collecting(state_next);
      timeout_err  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_pass_entry.sv
// Directed bench for pass_entry with TIMEOUT_CYCLES=16: a vector table for
// the main flows plus hand sequences for timeout, terminal-count and reset.
module tb_pass_entry;

  localparam int TIMEOUT_CYCLES = 16;

  logic       clk;
  logic       reset_n;
  logic       sensor_entrance;
  logic       key_valid;
  logic [1:0] key_code;
  logic       key_clear;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       pass_valid;
  logic       entry_active;
  logic       timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  pass_entry #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_clear       (key_clear),
    .password_1      (password_1),
    .password_2      (password_2),
    .pass_valid      (pass_valid),
    .entry_active    (entry_active),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {password_1, password_2, pass_valid, entry_active, timeout_err}.
  typedef struct {
    logic       sensor;
    logic       kv;
    logic [1:0] code;
    logic       kc;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] outs(input int p1, input int p2,
                                      input bit pv, input bit ea, input bit to);
    return {2'(p1), 2'(p2), pv, ea, to};
  endfunction

  function automatic logic [6:0] actual();
    return {password_1, password_2, pass_valid, entry_active, timeout_err};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got p1p2_pv_ea_to=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic kv, input logic [1:0] code, input logic kc);
    sensor_entrance = s;
    key_valid       = kv;
    key_code        = code;
    key_clear       = kc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic kv, input logic [1:0] code,
                     input logic kc, input logic [6:0] exp);
    vec_t v;
    v.sensor = s; v.kv = kv; v.code = code; v.kc = kc; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main flows, one row per clock: inputs for the cycle, outputs after the edge.
    add(1, 0, 0, 0, outs(0, 0, 0, 1, 0));  // car arrives
    add(1, 1, 1, 0, outs(1, 0, 0, 1, 0));  // digit 1
    add(1, 1, 2, 0, outs(1, 2, 1, 0, 0));  // digit 2 -> SEND
    add(1, 1, 3, 0, outs(1, 2, 1, 0, 0));  // key ignored in SEND
    add(0, 0, 0, 0, outs(0, 0, 0, 0, 0));  // car leaves
    add(0, 1, 3, 0, outs(0, 0, 0, 0, 0));  // key ignored in IDLE
    add(1, 0, 0, 0, outs(0, 0, 0, 1, 0));
    add(1, 1, 2, 0, outs(2, 0, 0, 1, 0));
    add(1, 0, 0, 1, outs(0, 0, 0, 1, 0));  // clear in WAIT_D2
    add(1, 1, 1, 0, outs(1, 0, 0, 1, 0));
    add(1, 1, 1, 0, outs(1, 1, 1, 0, 0));
    add(1, 0, 0, 1, outs(0, 0, 0, 1, 0));  // clear in SEND
    add(1, 1, 3, 0, outs(3, 0, 0, 1, 0));
    add(1, 1, 1, 1, outs(0, 0, 0, 1, 0));  // clear beats key in WAIT_D2
    add(1, 1, 2, 0, outs(2, 0, 0, 1, 0));  // back in WAIT_D1
    add(0, 1, 3, 1, outs(0, 0, 0, 0, 0));  // sensor drop beats everything
    add(1, 1, 1, 0, outs(0, 0, 0, 1, 0));  // key on IDLE->WAIT_D1 cycle ignored
    add(1, 1, 0, 0, outs(0, 0, 0, 1, 0));
    add(1, 1, 3, 0, outs(0, 3, 1, 0, 0));
    add(0, 0, 0, 0, outs(0, 0, 0, 0, 0));

    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    check("reset_state", actual(), outs(0, 0, 0, 0, 0));
    reset_n = 1'b1;
    tick();
    check("idle_after_release", actual(), outs(0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sensor, vecs[i].kv, vecs[i].code, vecs[i].kc);
      tick();
      check($sformatf("vec[%0d]", i), actual(), vecs[i].exp);
    end

    // Timeout in WAIT_D2: 16 keyless cycles after the first digit.
    drive(1, 0, 0, 0);
    tick();
    drive(1, 1, 3, 0);
    tick();
    check("to_first_digit", actual(), outs(3, 0, 0, 1, 0));
    drive(1, 0, 0, 0);
    for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
      tick();
      check($sformatf("to_wait_%0d", i), actual(), outs(3, 0, 0, 1, 0));
    end
    tick();
    check("to_pulse", actual(), outs(0, 0, 0, 0, 1));
    tick();
    check("to_pulse_single", actual(), outs(0, 0, 0, 1, 0));  // car still there -> re-arm
    drive(0, 0, 0, 0);
    tick();
    check("to_leave", actual(), outs(0, 0, 0, 0, 0));

    // Key on the terminal-count cycle in WAIT_D1 is accepted, no timeout.
    drive(1, 0, 0, 0);
    tick();
    for (int i = 1; i < TIMEOUT_CYCLES; i++) tick();
    check("tc_before_key", actual(), outs(0, 0, 0, 1, 0));
    drive(1, 1, 2, 0);
    tick();
    check("tc_key_accepted", actual(), outs(2, 0, 0, 1, 0));
    drive(1, 1, 1, 0);
    tick();
    check("tc_send", actual(), outs(2, 1, 1, 0, 0));

    // Asynchronous reset mid-SEND, then a new entry needs the sensor.
    drive(1, 1, 0, 0);
    tick();
    check("send_key_ignored", actual(), outs(2, 1, 1, 0, 0));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_now", actual(), outs(0, 0, 0, 0, 0));
    drive(0, 0, 0, 0);
    #3;
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", actual(), outs(0, 0, 0, 0, 0));
    drive(1, 0, 0, 0);
    tick();
    check("post_reset_entry", actual(), outs(0, 0, 0, 1, 0));
    drive(0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
